mmio_bus_ctrl: RTL and testbench

Sequences the core's single memory-mapped data port onto N peripheral targets (timer, VGA, stdout, spare). It decodes the request address, drives a one-hot target select and holds it until that target acknowledges. It returns read data and a single-cycle ready to the core. It also turns unmapped addresses and unresponsive targets into a bus-error completion, so the core never hangs on the d_valid/d_ready handshake.

---
 rtl/mmio_bus_ctrl.sv | 125 ++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: decodes one core data request onto N_DEV targets,
// waits for the selected target's ack (or times out) and returns a one-cycle ready.
module mmio_bus_ctrl #(
  parameter int N_DEV = 4,
  parameter logic [N_DEV*64-1:0] DEV_BASE = {64'h2000_0040, 64'h2000_0020,
                                             64'h1000_0000, 64'h2000_0000},
  parameter logic [N_DEV*64-1:0] DEV_MASK = {64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF0,
                                             64'hFFFF_FFFF_FFF0_0000, 64'hFFFF_FFFF_FFFF_FFF0},
  parameter int TIMEOUT = 16,
  parameter int ST_W = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [63:0]           req_addr,
  input  logic [63:0]           req_wdata,
  input  logic [ST_W-1:0]       req_store_type,
  output logic                  req_ready,
  output logic [63:0]           req_rdata,
  output logic                  req_err,
  output logic [N_DEV-1:0]      dev_sel,
  output logic [63:0]           dev_addr,
  output logic [63:0]           dev_wdata,
  output logic [ST_W-1:0]       dev_store_type,
  input  logic [N_DEV*64-1:0]   dev_rdata,
  input  logic [N_DEV-1:0]      dev_ack
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [N_DEV-1:0]   hit;
  logic [N_DEV-1:0]   win_sel;
  logic [63:0]        sel_rdata;
  logic               sel_ack;

  // Address decode; scanning from the top down leaves the lowest hitting index as winner.
  always_comb begin
    hit     = '0;
    win_sel = '0;
    for (int i = 0; i < N_DEV; i++) begin
      hit[i] = ((req_addr & DEV_MASK[64*i +: 64]) == DEV_BASE[64*i +: 64]);
    end
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        win_sel    = '0;
        win_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_sel[i]) begin
        sel_rdata = sel_rdata | dev_rdata[64*i +: 64];
      end
    end
  end

  assign sel_ack = |(dev_ack & dev_sel);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      dev_sel        <= '0;
      dev_addr       <= '0;
      dev_wdata      <= '0;
      dev_store_type <= '0;
      req_ready      <= 1'b0;
      req_err        <= 1'b0;
      req_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b0;
          req_err   <= 1'b0;
          req_rdata <= '0;
          // The ready pulse lands in an IDLE cycle while the core still holds
          // req_valid, so that cycle must not start a new transaction.
          if (req_valid && !req_ready) begin
            dev_addr  <= req_addr;
            dev_wdata <= req_wdata;
            cnt       <= '0;
            if (|hit) begin
              dev_sel        <= win_sel;
              dev_store_type <= req_store_type;
              state          <= WAIT;
            end else begin
              req_err <= 1'b1;
              state   <= RESP;
            end
          end
        end
        WAIT: begin
          if (sel_ack) begin
            req_rdata      <= sel_rdata;
            req_err        <= 1'b0;
            dev_sel        <= '0;
            dev_store_type <= '0;
            state          <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            req_rdata      <= '0;
            req_err        <= 1'b1;
            dev_sel        <= '0;
            dev_store_type <= '0;
            state          <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed bench for mmio_bus_ctrl: a small target responder acks after a chosen
// number of select cycles; latency, selects, data and error are checked per request.
module tb_mmio_bus_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic         req_valid;
  logic [63:0]  req_addr;
  logic [63:0]  req_wdata;
  logic [2:0]   req_store_type;
  logic         req_ready;
  logic [63:0]  req_rdata;
  logic         req_err;
  logic [3:0]   dev_sel;
  logic [63:0]  dev_addr;
  logic [63:0]  dev_wdata;
  logic [2:0]   dev_store_type;
  logic [255:0] dev_rdata;
  logic [3:0]   dev_ack;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] RD0 = 64'h0000_0000_DEAD_BEEF;
  localparam logic [63:0] RD1 = 64'h1111_0000_1111_0001;
  localparam logic [63:0] RD2 = 64'h2222_0000_2222_0002;
  localparam logic [63:0] RD3 = 64'h3333_0000_3333_0003;

  mmio_bus_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_store_type (req_store_type),
    .req_ready      (req_ready),
    .req_rdata      (req_rdata),
    .req_err        (req_err),
    .dev_sel        (dev_sel),
    .dev_addr       (dev_addr),
    .dev_wdata      (dev_wdata),
    .dev_store_type (dev_store_type),
    .dev_rdata      (dev_rdata),
    .dev_ack        (dev_ack)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one request and plays the target: ack_who is driven from select cycle ack_at on
  // (ack_at=0 never acks). req_valid stays high through the ready cycle and one more cycle.
  task automatic applyStimulus(input string name, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [2:0] st, input logic [3:0] ack_who, input int ack_at,
                               input int exp_lat, input logic [3:0] exp_sel, input int exp_sel_cycles,
                               input logic [63:0] exp_rdata, input logic exp_err);
    int          lat = 0;
    int          sel_cycles = 0;
    logic [3:0]  sel_seen = '0;
    logic        held_ok = 1'b1;
    logic        got = 1'b0;
    logic [63:0] rdata = '0;
    logic        err = 1'b0;
    req_valid      = 1'b1;
    req_addr       = addr;
    req_wdata      = wdata;
    req_store_type = st;
    while (!got && lat < 40) begin
      step();
      lat++;
      if (req_ready) begin
        got     = 1'b1;
        rdata   = req_rdata;
        err     = req_err;
        dev_ack = '0;
      end else begin
        if (dev_sel != '0) begin
          sel_cycles++;
          sel_seen = sel_seen | dev_sel;
          if (dev_addr !== addr || dev_wdata !== wdata || dev_store_type !== st) held_ok = 1'b0;
        end
        dev_ack = (dev_sel != '0 && ack_at != 0 && sel_cycles >= ack_at) ? ack_who : 4'b0000;
      end
    end
    checkOutput({name, "_ready_seen"}, 64'(got), 64'd1);
    checkOutput({name, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({name, "_sel"}, 64'(sel_seen), 64'(exp_sel));
    checkOutput({name, "_sel_cycles"}, 64'(sel_cycles), 64'(exp_sel_cycles));
    checkOutput({name, "_held"}, 64'(held_ok), 64'd1);
    checkOutput({name, "_rdata"}, rdata, exp_rdata);
    checkOutput({name, "_err"}, 64'(err), 64'(exp_err));
    step();
    checkOutput({name, "_ready_clr"}, 64'(req_ready), 64'd0);
    checkOutput({name, "_no_reaccept"}, 64'(dev_sel), 64'd0);
    checkOutput({name, "_err_clr"}, 64'(req_err), 64'd0);
    checkOutput({name, "_rdata_clr"}, req_rdata, 64'd0);
    checkOutput({name, "_st_clr"}, 64'(dev_store_type), 64'd0);
    req_valid = 1'b0;
  endtask

  initial begin
    logic saw_ready;
    dev_rdata      = {RD3, RD2, RD1, RD0};
    dev_ack        = '0;
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_wdata      = '0;
    req_store_type = '0;
    step();
    step();
    checkOutput("rst_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_sel", 64'(dev_sel), 64'd0);
    checkOutput("rst_err", 64'(req_err), 64'd0);
    checkOutput("rst_rdata", req_rdata, 64'd0);
    checkOutput("rst_addr", dev_addr, 64'd0);
    checkOutput("rst_wdata", dev_wdata, 64'd0);
    checkOutput("rst_st", 64'(dev_store_type), 64'd0);
    reset = 1'b0;
    step();

    $display("[TB] directed transactions");
    applyStimulus("rd_dev0", 64'h2000_0008, 64'h0, 3'd0, 4'b0001, 1, 3, 4'b0001, 1, RD0, 1'b0);
    step();
    applyStimulus("wr_dev2", 64'h2000_0020, 64'h41, 3'd3, 4'b0100, 5, 7, 4'b0100, 5, RD2, 1'b0);
    step();
    applyStimulus("unmapped", 64'h4000_0000, 64'h0, 3'd0, 4'b0000, 0, 2, 4'b0000, 0, 64'h0, 1'b1);
    step();
    applyStimulus("edge_unmapped", 64'h2000_0010, 64'h0, 3'd0, 4'b0000, 0, 2, 4'b0000, 0, 64'h0, 1'b1);
    step();
    applyStimulus("high_unmapped", 64'h1_2000_0000, 64'h0, 3'd0, 4'b0000, 0, 2, 4'b0000, 0, 64'h0, 1'b1);
    step();
    applyStimulus("dev1_timeout", 64'h1000_1234, 64'h0, 3'd0, 4'b0000, 0, 18, 4'b0010, 16, 64'h0, 1'b1);
    step();
    applyStimulus("dev1_late_ack", 64'h1000_1234, 64'h0, 3'd0, 4'b0010, 16, 18, 4'b0010, 16, RD1, 1'b0);
    step();
    applyStimulus("wrong_ack", 64'h2000_0004, 64'h0, 3'd0, 4'b1000, 1, 18, 4'b0001, 16, 64'h0, 1'b1);
    step();
    applyStimulus("dev3_top", 64'h2000_004F, 64'h0, 3'd0, 4'b1000, 1, 3, 4'b1000, 1, RD3, 1'b0);

    $display("[TB] back-to-back with req_valid held");
    applyStimulus("b2b_first", 64'h2000_0048, 64'h7, 3'd1, 4'b1000, 1, 3, 4'b1000, 1, RD3, 1'b0);
    applyStimulus("b2b_second", 64'h2000_0000, 64'h9, 3'd2, 4'b0001, 2, 4, 4'b0001, 2, RD0, 1'b0);
    step();

    $display("[TB] reset during WAIT");
    req_valid      = 1'b1;
    req_addr       = 64'h2000_0000;
    req_wdata      = 64'h55;
    req_store_type = 3'd1;
    step();
    step();
    step();
    checkOutput("midrst_pre_sel", 64'(dev_sel), 64'd1);
    reset = 1'b1;
    step();
    checkOutput("midrst_sel", 64'(dev_sel), 64'd0);
    checkOutput("midrst_ready", 64'(req_ready), 64'd0);
    checkOutput("midrst_addr", dev_addr, 64'd0);
    checkOutput("midrst_st", 64'(dev_store_type), 64'd0);
    reset     = 1'b0;
    req_valid = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_ready) saw_ready = 1'b1;
    end
    checkOutput("midrst_no_ready", 64'(saw_ready), 64'd0);
    applyStimulus("after_rst", 64'h2000_0008, 64'h0, 3'd0, 4'b0001, 1, 3, 4'b0001, 1, RD0, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
